// File: rtl/lcd_ctrl.sv
// HD44780 4-bit write-only LCD sequencer: power-on init, then one byte per
// CPU write sent as two timed nibbles followed by an execution wait.
//   clk, rst        : clock, synchronous active-high reset
//   wr, wr_data,    : byte write strobe, byte, register select
//   wr_rs
//   busy, init_done : CPU status; drop flags a write lost while busy
//   lcd_e/rw/rs/db  : LCD bus (DB[7:4] only, rw tied low)
module lcd_ctrl #(
   parameter int unsigned E_SETUP      = 2,
   parameter int unsigned E_WIDTH      = 13,
   parameter int unsigned E_HOLD       = 2,
   parameter int unsigned CMD_WAIT     = 1080,
   parameter int unsigned CLEAR_WAIT   = 41000,
   parameter int unsigned POWERON_WAIT = 405000,
   parameter int unsigned INIT_WAIT1   = 110700,
   parameter int unsigned INIT_WAIT2   = 2700,
   parameter int unsigned CNT_WIDTH    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr,
   input  logic [7:0] wr_data,
   input  logic       wr_rs,
   output logic       busy,
   output logic       init_done,
   output logic       drop,
   output logic       lcd_e,
   output logic       lcd_rw,
   output logic       lcd_rs,
   output logic [3:0] lcd_db
);

   typedef enum logic [2:0] {
      PWR_WAIT, SETUP, E_HI, HOLD, WAIT, IDLE
   } state_t;

   // step 0..3 are the init nibbles, ST_HI/ST_LO the halves of a CPU byte
   localparam logic [2:0] ST_HI = 3'd4;
   localparam logic [2:0] ST_LO = 3'd5;

   state_t               state;
   logic [2:0]           step;
   logic [7:0]           byte_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] lim;
   logic                 done;
   logic                 is_clr;

   // last count value of a phase; a zero-length phase still takes a cycle
   function automatic logic [CNT_WIDTH-1:0] last_of(input int unsigned p);
      return (p == 0) ? '0 : CNT_WIDTH'(p - 1);
   endfunction

   assign lcd_rw = 1'b0;

   // clear (0x01) and return-home (0x02/0x03) need the long wait
   assign is_clr = !lcd_rs && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);

   always_comb begin
      lim = '0;
      unique case (state)
         PWR_WAIT: lim = last_of(POWERON_WAIT);
         SETUP:    lim = last_of(E_SETUP);
         E_HI:     lim = last_of(E_WIDTH);
         HOLD:     lim = last_of(E_HOLD);
         WAIT: begin
            if (step == 3'd0)      lim = last_of(INIT_WAIT1);
            else if (step == 3'd1) lim = last_of(INIT_WAIT2);
            else if (is_clr)       lim = last_of(CLEAR_WAIT);
            else                   lim = last_of(CMD_WAIT);
         end
         default:  lim = '0;
      endcase
   end

   // counter runs up from 0 each phase; every phase change happens on done
   assign done = (cnt == lim);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWR_WAIT;
         cnt       <= '0;
         step      <= '0;
         byte_q    <= '0;
         busy      <= 1'b1;
         init_done <= 1'b0;
         drop      <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_db    <= '0;
      end else begin
         if (wr && busy) drop <= 1'b1;
         cnt <= done ? '0 : cnt + 1'b1;
         unique case (state)
            PWR_WAIT: if (done) begin
               state  <= SETUP;
               step   <= 3'd0;
               lcd_rs <= 1'b0;
               lcd_db <= 4'h3;
            end
            SETUP: if (done) begin
               state <= E_HI;
               lcd_e <= 1'b1;
            end
            E_HI: if (done) begin
               state <= HOLD;
               lcd_e <= 1'b0;
            end
            HOLD: if (done) begin
               if (step == ST_HI) begin
                  state  <= SETUP;
                  step   <= ST_LO;
                  lcd_db <= byte_q[3:0];
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (done) begin
               if (step < 3'd3) begin
                  state  <= SETUP;
                  step   <= step + 3'd1;
                  lcd_db <= (step == 3'd2) ? 4'h2 : 4'h3;
               end else begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
               end
            end
            IDLE: if (wr) begin
               state  <= SETUP;
               step   <= ST_HI;
               busy   <= 1'b1;
               byte_q <= wr_data;
               lcd_rs <= wr_rs;
               lcd_db <= wr_data[7:4];
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl with shortened timing parameters.
// Scoreboard of expected nibbles checked on every E pulse, plus vector table.
module tb_lcd_ctrl;

   localparam int ES  = 2;
   localparam int EW  = 3;
   localparam int EH  = 1;
   localparam int CW  = 5;
   localparam int CLW = 20;
   localparam int PW  = 10;
   localparam int IW1 = 8;
   localparam int IW2 = 4;
   localparam int NIB = ES + EW + EH;
   localparam int INIT_LEN = PW + 4 * NIB + IW1 + IW2 + CW + CW;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_rs = 1'b0;
   logic       busy, init_done, drop;
   logic       lcd_e, lcd_rw, lcd_rs;
   logic [3:0] lcd_db;

   lcd_ctrl #(
      .E_SETUP(ES), .E_WIDTH(EW), .E_HOLD(EH),
      .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .POWERON_WAIT(PW),
      .INIT_WAIT1(IW1), .INIT_WAIT2(IW2), .CNT_WIDTH(20)
   ) dut (
      .clk(clk), .rst(rst), .wr(wr), .wr_data(wr_data), .wr_rs(wr_rs),
      .busy(busy), .init_done(init_done), .drop(drop),
      .lcd_e(lcd_e), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_db(lcd_db)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] exp_q[$];
   bit         cut_pulse = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // E pulse monitor: nibble order, width and hold of rs/db
   bit         e_prev = 1'b0;
   int         e_w = 0;
   logic [4:0] at_rise = '0;
   always @(negedge clk) begin
      chk("lcd_rw", int'(lcd_rw), 0);
      if (lcd_e === 1'b1 && !e_prev) begin
         at_rise = {lcd_rs, lcd_db};
         e_w = 1;
         if (exp_q.size() == 0) chk("e_unexpected", 1, 0);
         else chk("e_nibble", int'({lcd_rs, lcd_db}), int'(exp_q.pop_front()));
      end else if (lcd_e === 1'b1) begin
         e_w++;
      end else if (e_prev && !cut_pulse) begin
         chk("e_width", e_w, EW);
         chk("e_hold", int'({lcd_rs, lcd_db}), int'(at_rise));
      end
      e_prev = (lcd_e === 1'b1);
   end

   task automatic run_init(input bit intr);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_e", int'(lcd_e), 0);
      chk("rst_rs", int'(lcd_rs), 0);
      chk("rst_db", int'(lcd_db), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_drop", int'(drop), 0);
      rst = 1'b0;
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      for (int k = 1; k <= INIT_LEN; k++) begin
         @(negedge clk);
         if (intr && k == 20) begin
            wr = 1'b1; wr_rs = 1'b0; wr_data = 8'h99;
         end else begin
            wr = 1'b0;
         end
         if (k == INIT_LEN - 1) begin
            chk("init_busy_pre", int'(busy), 1);
            chk("init_done_pre", int'(init_done), 0);
         end
         if (k == INIT_LEN) begin
            chk("init_busy_end", int'(busy), 0);
            chk("init_done_end", int'(init_done), 1);
         end
      end
      cut_pulse = 1'b0;
      chk("init_pulses_left", exp_q.size(), 0);
      chk("init_drop", int'(drop), int'(intr));
   endtask

   // call with DUT idle; returns on the first idle cycle after the byte
   task automatic send(input logic rs, input logic [7:0] d,
                       input int exp_len, input int intr);
      int n;
      wr = 1'b1; wr_rs = rs; wr_data = d;
      exp_q.push_back({rs, d[7:4]});
      exp_q.push_back({rs, d[3:0]});
      @(negedge clk);
      wr = 1'b0;
      chk("acc_busy", int'(busy), 1);
      chk("acc_rs", int'(lcd_rs), int'(rs));
      chk("acc_db", int'(lcd_db), int'(d[7:4]));
      n = 0;
      for (int g = 0; g < 200 && busy === 1'b1; g++) begin
         n++;
         if (intr != 0 && n == intr) begin
            wr = 1'b1; wr_rs = 1'b1; wr_data = 8'hFF;
         end else begin
            wr = 1'b0;
         end
         @(negedge clk);
      end
      wr = 1'b0;
      chk("busy_len", n, exp_len);
   endtask

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         busy_len;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int g;
      vecs[0] = '{1'b1, 8'h41, 17};
      vecs[1] = '{1'b0, 8'h01, 32};
      vecs[2] = '{1'b0, 8'h02, 32};
      vecs[3] = '{1'b0, 8'h03, 32};
      vecs[4] = '{1'b0, 8'h00, 17};
      vecs[5] = '{1'b0, 8'h80, 17};
      vecs[6] = '{1'b0, 8'h04, 17};
      vecs[7] = '{1'b1, 8'h01, 17};

      @(negedge clk);
      run_init(1'b0);

      // back-to-back: each send starts on the first idle cycle
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].rs, vecs[i].data, vecs[i].busy_len, 0);
         chk("b2b_drop", int'(drop), 0);
      end

      // write 5 cycles into a transfer is dropped, transfer unchanged
      send(1'b1, 8'h5A, 17, 5);
      chk("drop_set", int'(drop), 1);
      repeat (3) @(negedge clk);
      chk("drop_sticky", int'(drop), 1);
      chk("drop_no_pulse", exp_q.size(), 0);

      // reset while E is high on the low nibble
      wr = 1'b1; wr_rs = 1'b1; wr_data = 8'h5A;
      exp_q.push_back(5'h15);
      exp_q.push_back(5'h1A);
      @(negedge clk);
      wr = 1'b0;
      g = 0;
      while (g < 50 && !(lcd_e === 1'b1 && lcd_db == 4'hA)) begin
         g++;
         @(negedge clk);
      end
      chk("lo_e_seen", int'(g < 50), 1);
      @(negedge clk);
      cut_pulse = 1'b1;
      run_init(1'b1);

      send(1'b1, 8'hC3, 17, 0);
      chk("final_drop", int'(drop), 1);
      repeat (4) @(negedge clk);
      chk("final_pulses_left", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
